// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetches and data loads/stores onto one single-port RAM
// with configurable latency and a data-first or round-robin contention policy.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LATENCY  = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_ren,
  output logic                ram_wen,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);
  localparam int BW = DATA_W / 8;
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              last_i_q, fetch_q, store_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic [BW-1:0]     be_q;
  logic              d_req, gnt_d;
  assign d_req = d_read | d_write;
  // On contention mode 1 hands the grant to whichever channel was not served last.
  assign gnt_d = d_req & (!i_req | (ARB_MODE == 0) | last_i_q);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_i_q  <= 1'b0;
      fetch_q   <= 1'b0;
      store_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_req | d_req) begin
          state_q  <= BUSY;
          cnt_q    <= CW'(LATENCY - 1);
          fetch_q  <= !gnt_d;
          store_q  <= gnt_d & d_write;
          last_i_q <= !gnt_d;
          addr_q   <= gnt_d ? d_addr : i_addr;
          wdata_q  <= gnt_d ? d_wdata : '0;
          be_q     <= (gnt_d & d_write) ? d_be : '1;
        end
        BUSY: if (cnt_q == '0) begin
          state_q <= RESP;
          if (fetch_q) i_rdata_q <= ram_rdata;
          else if (!store_q) d_rdata_q <= ram_rdata;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = state_q != IDLE;
  assign ram_ren   = (state_q == BUSY) & !store_q;
  assign ram_wen   = (state_q == BUSY) & store_q;
  assign ram_addr  = (state_q == BUSY) ? addr_q : '0;
  assign ram_wdata = (state_q == BUSY) ? wdata_q : '0;
  assign ram_be    = (state_q == BUSY) ? be_q : '0;
  assign i_ready   = (state_q == RESP) & fetch_q;
  assign d_ready   = (state_q == RESP) & !fetch_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiter configurations (L2/data-first, L2/round-robin, L1/data-first)
// driven by directed vectors; ready pulses are checked against a queue of expected responses.
module tb_mem_arbiter;
  logic clk = 1'b0, nrst = 1'b0;
  always #5 clk = ~clk;
  logic        i_req[3], d_read[3], d_write[3], i_ready[3], d_ready[3];
  logic        ram_ren[3], ram_wen[3], busy[3];
  logic [31:0] i_addr[3], d_addr[3], d_wdata[3], i_rdata[3], d_rdata[3];
  logic [31:0] ram_addr[3], ram_wdata[3], ram_rdata[3];
  logic [3:0]  d_be[3], ram_be[3];
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a == 32'h0) ? 32'h3E80_0093 : a * 3 + 32'h1000;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(g == 2 ? 1 : 2), .ARB_MODE(g == 1 ? 1 : 0)) dut (
      .clk(clk), .nrst(nrst), .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ready(i_ready[g]),
      .i_rdata(i_rdata[g]), .d_read(d_read[g]), .d_write(d_write[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_be(d_be[g]), .d_ready(d_ready[g]), .d_rdata(d_rdata[g]),
      .ram_addr(ram_addr[g]), .ram_ren(ram_ren[g]), .ram_wen(ram_wen[g]),
      .ram_wdata(ram_wdata[g]), .ram_be(ram_be[g]), .ram_rdata(ram_rdata[g]), .busy(busy[g]));
    assign ram_rdata[g] = f(ram_addr[g]);
  end
  typedef struct {int dut; logic ch; logic [31:0] data; int cyc;} exp_t;
  exp_t exp_q[$];
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input int k, input logic ch, input logic [31:0] data, input int c);
    exp_t e;
    e.dut = k; e.ch = ch; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (nrst) for (int k = 0; k < 3; k++) if (i_ready[k] | d_ready[k]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: dut%0d i_ready=%b d_ready=%b cycle %0d", k, i_ready[k], d_ready[k], cyc);
      end else begin
        e = exp_q.pop_front();
        chk("resp_dut", k, e.dut);
        chk("resp_channel", {31'b0, i_ready[k]}, {31'b0, e.ch});
        chk("resp_both_ready", {31'b0, i_ready[k] & d_ready[k]}, 32'h0);
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_data", i_ready[k] ? i_rdata[k] : d_rdata[k], e.data);
      end
    end
  end
  task automatic chk_idle(input int k, input string name);
    chk({name, "_busy"}, {31'b0, busy[k]}, 32'h0);
    chk({name, "_ren"}, {31'b0, ram_ren[k]}, 32'h0);
    chk({name, "_wen"}, {31'b0, ram_wen[k]}, 32'h0);
  endtask
  int c0;
  initial begin
    for (int k = 0; k < 3; k++) begin
      i_req[k] = 0; d_read[k] = 0; d_write[k] = 0;
      i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; d_be[k] = 0;
    end
    step(2);
    for (int k = 0; k < 3; k++) begin
      chk_idle(k, "reset");
      chk("reset_i_rdata", i_rdata[k], 32'h0);
      chk("reset_d_rdata", d_rdata[k], 32'h0);
      chk("reset_ram_addr", ram_addr[k], 32'h0);
      chk("reset_ram_be", {28'b0, ram_be[k]}, 32'h0);
    end
    nrst = 1'b1;
    step(1);
    // fetch, latency 2
    c0 = cyc;
    push(0, 1'b1, 32'h3E80_0093, c0 + 3);
    i_req[0] = 1; i_addr[0] = 32'h0;
    step(1);
    chk("fetch_ren_c1", {31'b0, ram_ren[0]}, 32'h1);
    chk("fetch_addr_c1", ram_addr[0], 32'h0);
    chk("fetch_be_c1", {28'b0, ram_be[0]}, 32'hF);
    step(1);
    chk("fetch_ren_c2", {31'b0, ram_ren[0]}, 32'h1);
    chk("fetch_wen_c2", {31'b0, ram_wen[0]}, 32'h0);
    step(1);
    i_req[0] = 0;
    chk("fetch_ren_c3", {31'b0, ram_ren[0]}, 32'h0);
    step(2);
    chk("fetch_rdata_held", i_rdata[0], 32'h3E80_0093);
    chk_idle(0, "fetch_after");
    // load, to give d_rdata a value a later store must preserve
    c0 = cyc;
    push(0, 1'b0, 32'h0000_1600, c0 + 3);
    d_read[0] = 1; d_addr[0] = 32'h200;
    step(3);
    d_read[0] = 0;
    step(1);
    // store with partial byte enables
    c0 = cyc;
    push(0, 1'b0, 32'h0000_1600, c0 + 3);
    d_write[0] = 1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF; d_be[0] = 4'b0011;
    step(1);
    chk("store_wen_c1", {31'b0, ram_wen[0]}, 32'h1);
    chk("store_ren_c1", {31'b0, ram_ren[0]}, 32'h0);
    chk("store_addr", ram_addr[0], 32'h100);
    chk("store_wdata", ram_wdata[0], 32'hDEAD_BEEF);
    chk("store_be", {28'b0, ram_be[0]}, 32'h3);
    step(1);
    chk("store_wen_c2", {31'b0, ram_wen[0]}, 32'h1);
    step(1);
    d_write[0] = 0;
    chk("store_wen_c3", {31'b0, ram_wen[0]}, 32'h0);
    chk("store_i_ready", {31'b0, i_ready[0]}, 32'h0);
    step(1);
    // reset in the middle of a store
    c0 = cyc;
    d_write[0] = 1; d_addr[0] = 32'h300; d_wdata[0] = 32'h5555_AAAA; d_be[0] = 4'hF;
    step(2);
    chk("abort_wen_before", {31'b0, ram_wen[0]}, 32'h1);
    nrst = 1'b0;
    d_write[0] = 0;
    #1;
    chk_idle(0, "abort");
    chk("abort_i_rdata", i_rdata[0], 32'h0);
    chk("abort_d_rdata", d_rdata[0], 32'h0);
    chk("abort_ram_addr", ram_addr[0], 32'h0);
    step(2);
    nrst = 1'b1;
    step(4);
    // first access after reset
    c0 = cyc;
    push(0, 1'b0, 32'h0000_10C0, c0 + 3);
    d_read[0] = 1; d_addr[0] = 32'h40;
    step(3);
    d_read[0] = 0;
    step(1);
    // contention, data-first
    c0 = cyc;
    push(0, 1'b0, f(32'h20), c0 + 3);
    push(0, 1'b1, f(32'h8), c0 + 7);
    i_req[0] = 1; i_addr[0] = 32'h8; d_read[0] = 1; d_addr[0] = 32'h20;
    step(1);
    chk("prio_first_addr", ram_addr[0], 32'h20);
    step(2);
    d_read[0] = 0;
    step(2);
    chk("prio_second_addr", ram_addr[0], 32'h8);
    step(2);
    i_req[0] = 0;
    step(2);
    // contention, round-robin over four grants
    c0 = cyc;
    push(1, 1'b1, f(32'h4), c0 + 3);
    push(1, 1'b0, f(32'h24), c0 + 7);
    push(1, 1'b1, f(32'h4), c0 + 11);
    push(1, 1'b0, f(32'h24), c0 + 15);
    i_req[1] = 1; i_addr[1] = 32'h4; d_read[1] = 1; d_addr[1] = 32'h24;
    step(15);
    i_req[1] = 0; d_read[1] = 0;
    step(2);
    chk_idle(1, "rr_after");
    // latency 1: read+write together is a store
    c0 = cyc;
    push(2, 1'b0, 32'h0, c0 + 2);
    d_read[2] = 1; d_write[2] = 1; d_addr[2] = 32'h40; d_wdata[2] = 32'h1234_5678; d_be[2] = 4'b1100;
    step(1);
    chk("l1_store_wen", {31'b0, ram_wen[2]}, 32'h1);
    chk("l1_store_ren", {31'b0, ram_ren[2]}, 32'h0);
    chk("l1_store_be", {28'b0, ram_be[2]}, 32'hC);
    chk("l1_store_wdata", ram_wdata[2], 32'h1234_5678);
    step(1);
    d_read[2] = 0; d_write[2] = 0;
    chk("l1_store_wen_c2", {31'b0, ram_wen[2]}, 32'h0);
    chk("l1_store_ren_c2", {31'b0, ram_ren[2]}, 32'h0);
    step(1);
    // latency 1 load
    c0 = cyc;
    push(2, 1'b0, 32'h0000_10CC, c0 + 2);
    d_read[2] = 1; d_addr[2] = 32'h44;
    step(1);
    chk("l1_load_ren", {31'b0, ram_ren[2]}, 32'h1);
    step(1);
    d_read[2] = 0;
    step(3);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
